// File: rtl/d_free_list_if.sv
// Allocation / free / commit / flush bundle between the D-register free list and rename/retire.
// slave = the free list itself, master = the rename/retire logic driving it.
interface d_free_list_if #(
    parameter int P_BITS = 5
) ();
    logic              alloc_valid;
    logic [P_BITS-1:0] alloc_tag;
    logic              alloc_ack;
    logic              free_valid;
    logic [P_BITS-1:0] free_tag;
    logic              commit_valid;
    logic              flush;
    logic [P_BITS:0]   free_count;
    logic              error;

    // alloc_valid/alloc_ack is a valid/ready pair: a tag is consumed only in a
    // cycle where both are high (and flush is low). free_valid, commit_valid and
    // flush are single-cycle strobes sampled at the rising clock edge.
    modport slave (
        output alloc_valid, alloc_tag, free_count, error,
        input  alloc_ack, free_valid, free_tag, commit_valid, flush
    );

    modport master (
        input  alloc_valid, alloc_tag, free_count, error,
        output alloc_ack, free_valid, free_tag, commit_valid, flush
    );
endinterface

// File: rtl/d_free_list.sv
// Circular free list of physical D-register tags with a commit head for flush rollback.
// Optional same-cycle free->alloc bypass on an empty list: define FREE_LIST_BYPASS_EN.
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif

module d_free_list #(
    parameter int NUM_P_REG = `NUM_D_REG,
    parameter int NUM_ARCH  = 16,
    parameter int P_BITS    = $clog2(NUM_P_REG)
) (
    input  logic          clk,
    input  logic          n_rst,
    d_free_list_if.slave  fl
);
    localparam int PTR_W = P_BITS + 1;

    logic [P_BITS-1:0] mem_q [NUM_P_REG];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  chead_q, chead_d;
    logic              error_q, error_d;

    logic [PTR_W-1:0]  count;
    logic              empty, full, bypass;
    logic              do_alloc, do_free, do_commit;

    assign count = tail_q - head_q;
    assign empty = (count == '0);
    assign full  = (count == PTR_W'(NUM_P_REG));

`ifdef FREE_LIST_BYPASS_EN
    assign bypass = empty & fl.free_valid;
`else
    assign bypass = 1'b0;
`endif

    assign fl.alloc_valid = ~empty | bypass;
    assign fl.alloc_tag   = bypass ? fl.free_tag : mem_q[head_q[P_BITS-1:0]];
    assign fl.free_count  = count;
    assign fl.error       = error_q;

    // All legality checks look at this cycle's registered pointers only.
    assign do_alloc  = fl.alloc_ack & ~fl.flush & fl.alloc_valid;
    assign do_free   = fl.free_valid & ~full;
    assign do_commit = fl.commit_valid & (chead_q != head_q);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        chead_d = chead_q;
        error_d = error_q;

        if (do_free)   tail_d  = tail_q + PTR_W'(1);
        if (do_commit) chead_d = chead_q + PTR_W'(1);

        // Flush rewinds to the post-commit head, discarding any ack this cycle.
        if (fl.flush)       head_d = chead_d;
        else if (do_alloc)  head_d = head_q + PTR_W'(1);

        if (fl.alloc_ack & ~fl.flush & ~fl.alloc_valid) error_d = 1'b1;
        if (fl.free_valid & full)                       error_d = 1'b1;
        if (fl.commit_valid & (chead_q == head_q))      error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            head_q  <= '0;
            chead_q <= '0;
            tail_q  <= PTR_W'(NUM_P_REG - NUM_ARCH);
            error_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            chead_q <= chead_d;
            tail_q  <= tail_d;
            error_q <= error_d;
        end
    end

    // Tags 0..NUM_ARCH-1 start out mapped, so only the rest are free at reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_P_REG; i++) begin
                mem_q[i] <= (i < NUM_P_REG - NUM_ARCH) ? P_BITS'(NUM_ARCH + i) : '0;
            end
        end else if (do_free) begin
            mem_q[tail_q[P_BITS-1:0]] <= fl.free_tag;
        end
    end
endmodule

// File: tb/tb_d_free_list.sv
// Self-checking bench for d_free_list: directed scenarios plus a random run against a queue model.
module tb_d_free_list;
    localparam int NP = 32;
    localparam int NA = 16;
    localparam int PB = 5;
`ifdef FREE_LIST_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst;
    int   checks = 0;
    int   failures = 0;

    // Model: exp_q = allocatable tags in allocation order, spec_q = allocated but not committed.
    logic [PB-1:0] exp_q[$];
    logic [PB-1:0] spec_q[$];
    logic          exp_err;

    d_free_list_if #(.P_BITS(PB)) fl_if ();

    d_free_list #(.NUM_P_REG(NP), .NUM_ARCH(NA), .P_BITS(PB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .fl    (fl_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic model_step();
        logic [PB-1:0] tmp[$];
        bit pre_empty  = (exp_q.size() == 0);
        bit pre_full   = (exp_q.size() == NP);
        bit spec_empty = (spec_q.size() == 0);
        bit valid      = !pre_empty || (BYP && fl_if.free_valid);
        if (fl_if.alloc_ack && !fl_if.flush && !valid) exp_err = 1'b1;
        if (fl_if.free_valid && pre_full) exp_err = 1'b1;
        if (fl_if.commit_valid && spec_empty) exp_err = 1'b1;
        if (fl_if.free_valid && !pre_full) exp_q.push_back(fl_if.free_tag);
        if (fl_if.alloc_ack && !fl_if.flush && valid) spec_q.push_back(exp_q.pop_front());
        if (fl_if.commit_valid && !spec_empty) void'(spec_q.pop_front());
        if (fl_if.flush) begin
            tmp = spec_q;
            foreach (exp_q[i]) tmp.push_back(exp_q[i]);
            exp_q = tmp;
            spec_q.delete();
        end
    endtask

    // Called in the negedge phase; leaves outputs settled for comparison.
    task automatic drive(input logic ack, input logic fv, input logic [PB-1:0] tag,
                         input logic cv, input logic fls);
        fl_if.alloc_ack    = ack;
        fl_if.free_valid   = fv;
        fl_if.free_tag     = tag;
        fl_if.commit_valid = cv;
        fl_if.flush        = fls;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (n_rst) model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        drive(0, 0, '0, 0, 0);
        @(posedge clk);
        exp_q.delete();
        spec_q.delete();
        for (int i = 0; i < NP - NA; i++) exp_q.push_back(PB'(NA + i));
        exp_err = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < NP - NA; i++) begin
            drive(1, 0, '0, 0, 0);
            tick();
        end
        drive(0, 0, '0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fl_if.free_count !== 6'd16) begin failures++; $display("FAIL reset_count got=%0d exp=16", fl_if.free_count); end
        checks++; if (fl_if.alloc_valid !== 1'b1) begin failures++; $display("FAIL reset_valid got=%0b exp=1", fl_if.alloc_valid); end
        checks++; if (fl_if.alloc_tag !== 5'd16) begin failures++; $display("FAIL reset_tag got=%0d exp=16", fl_if.alloc_tag); end
        checks++; if (fl_if.error !== 1'b0) begin failures++; $display("FAIL reset_error got=%0b exp=0", fl_if.error); end
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i < NP - NA; i++) begin
            drive(1, 0, '0, 0, 0);
            checks++; if (fl_if.alloc_tag !== PB'(NA + i)) begin failures++; $display("FAIL drain_tag[%0d] got=%0d exp=%0d", i, fl_if.alloc_tag, NA + i); end
            checks++; if (fl_if.free_count !== 6'(NP - NA - i)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, fl_if.free_count, NP - NA - i); end
            tick();
        end
        drive(0, 0, '0, 0, 0);
        checks++; if (fl_if.alloc_valid !== 1'b0) begin failures++; $display("FAIL drain_empty_valid got=%0b exp=0", fl_if.alloc_valid); end
        checks++; if (fl_if.free_count !== 6'd0) begin failures++; $display("FAIL drain_empty_count got=%0d exp=0", fl_if.free_count); end
        checks++; if (fl_if.error !== 1'b0) begin failures++; $display("FAIL drain_error got=%0b exp=0", fl_if.error); end
    endtask

    task automatic test_underflow();
        // Continues from the empty list left by test_drain.
        drive(1, 0, '0, 0, 0);
        tick();
        drive(0, 0, '0, 0, 0);
        checks++; if (fl_if.error !== 1'b1) begin failures++; $display("FAIL underflow_error got=%0b exp=1", fl_if.error); end
        checks++; if (fl_if.free_count !== 6'd0) begin failures++; $display("FAIL underflow_count got=%0d exp=0", fl_if.free_count); end
        checks++; if (fl_if.alloc_valid !== 1'b0) begin failures++; $display("FAIL underflow_valid got=%0b exp=0", fl_if.alloc_valid); end
    endtask

    task automatic test_refill();
        do_reset();
        drain();
        drive(0, 1, 5'd5, 0, 0);
        tick();
        drive(0, 1, 5'd9, 0, 0);
        checks++; if (fl_if.alloc_tag !== 5'd5) begin failures++; $display("FAIL refill_tag_first got=%0d exp=5", fl_if.alloc_tag); end
        tick();
        drive(0, 0, '0, 0, 0);
        checks++; if (fl_if.free_count !== 6'd2) begin failures++; $display("FAIL refill_count got=%0d exp=2", fl_if.free_count); end
        checks++; if (fl_if.alloc_tag !== 5'd5) begin failures++; $display("FAIL refill_tag5 got=%0d exp=5", fl_if.alloc_tag); end
        drive(1, 0, '0, 0, 0);
        tick();
        drive(0, 0, '0, 0, 0);
        checks++; if (fl_if.alloc_tag !== 5'd9) begin failures++; $display("FAIL refill_tag9 got=%0d exp=9", fl_if.alloc_tag); end
        checks++; if (fl_if.error !== 1'b0) begin failures++; $display("FAIL refill_error got=%0b exp=0", fl_if.error); end
    endtask

    task automatic test_rollback();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, '0, 0, 0);
            checks++; if (fl_if.alloc_tag !== PB'(NA + i)) begin failures++; $display("FAIL rollback_alloc[%0d] got=%0d exp=%0d", i, fl_if.alloc_tag, NA + i); end
            tick();
        end
        drive(0, 0, '0, 1, 0);
        tick();
        drive(0, 0, '0, 0, 1);
        tick();
        drive(0, 0, '0, 0, 0);
        checks++; if (fl_if.alloc_tag !== 5'd17) begin failures++; $display("FAIL rollback_tag got=%0d exp=17", fl_if.alloc_tag); end
        checks++; if (fl_if.free_count !== 6'd15) begin failures++; $display("FAIL rollback_count got=%0d exp=15", fl_if.free_count); end
        checks++; if (fl_if.error !== 1'b0) begin failures++; $display("FAIL rollback_error got=%0b exp=0", fl_if.error); end
    endtask

    task automatic test_flush_commit();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, '0, 0, 0);
            tick();
        end
        // ack in a flush cycle must be dropped silently
        drive(1, 0, '0, 1, 1);
        tick();
        drive(0, 0, '0, 0, 0);
        checks++; if (fl_if.alloc_tag !== 5'd17) begin failures++; $display("FAIL flush_commit_tag got=%0d exp=17", fl_if.alloc_tag); end
        checks++; if (fl_if.free_count !== 6'd15) begin failures++; $display("FAIL flush_commit_count got=%0d exp=15", fl_if.free_count); end
        checks++; if (fl_if.error !== 1'b0) begin failures++; $display("FAIL flush_commit_error got=%0b exp=0", fl_if.error); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(0, 1, PB'($urandom_range(0, NP - 1)), 0, 0);
            tick();
            drive(0, 0, '0, 0, 0);
            if (i == 15) begin
                checks++; if (fl_if.error !== 1'b0) begin failures++; $display("FAIL overflow_pre_error got=%0b exp=0", fl_if.error); end
                checks++; if (fl_if.free_count !== 6'd32) begin failures++; $display("FAIL overflow_full_count got=%0d exp=32", fl_if.free_count); end
            end
        end
        checks++; if (fl_if.error !== 1'b1) begin failures++; $display("FAIL overflow_error got=%0b exp=1", fl_if.error); end
        checks++; if (fl_if.free_count !== 6'd32) begin failures++; $display("FAIL overflow_count got=%0d exp=32", fl_if.free_count); end
        checks++; if (fl_if.alloc_tag !== exp_q[0]) begin failures++; $display("FAIL overflow_head_tag got=%0d exp=%0d", fl_if.alloc_tag, exp_q[0]); end
    endtask

    task automatic test_bypass();
        do_reset();
        drain();
        drive(1, 1, 5'd7, 0, 0);
        checks++; if (fl_if.alloc_valid !== BYP) begin failures++; $display("FAIL bypass_valid got=%0b exp=%0b", fl_if.alloc_valid, BYP); end
        if (BYP) begin
            checks++; if (fl_if.alloc_tag !== 5'd7) begin failures++; $display("FAIL bypass_tag got=%0d exp=7", fl_if.alloc_tag); end
        end
        tick();
        drive(0, 0, '0, 0, 0);
        checks++; if (fl_if.free_count !== (BYP ? 6'd0 : 6'd1)) begin failures++; $display("FAIL bypass_count got=%0d exp=%0d", fl_if.free_count, BYP ? 0 : 1); end
        checks++; if (fl_if.error !== !BYP) begin failures++; $display("FAIL bypass_error got=%0b exp=%0b", fl_if.error, !BYP); end
    endtask

    task automatic test_random();
        logic          ack, fv, cv, fls;
        logic [PB-1:0] tag;
        logic          e_valid;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            ack = (exp_q.size() != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            fv  = (exp_q.size() + spec_q.size() < NP) && ($urandom_range(0, 2) == 0);
            tag = PB'($urandom_range(0, NP - 1));
            cv  = ($urandom_range(0, 3) == 0);
            fls = ($urandom_range(0, 15) == 0);
            drive(ack, fv, tag, cv, fls);
            e_valid = (exp_q.size() != 0) || (BYP && fv);
            checks++; if (fl_if.alloc_valid !== e_valid) begin failures++; $display("FAIL rand_valid[%0d] got=%0b exp=%0b", c, fl_if.alloc_valid, e_valid); end
            if (e_valid) begin
                checks++; if (fl_if.alloc_tag !== ((exp_q.size() != 0) ? exp_q[0] : tag)) begin failures++; $display("FAIL rand_tag[%0d] got=%0d exp=%0d", c, fl_if.alloc_tag, (exp_q.size() != 0) ? exp_q[0] : tag); end
            end
            checks++; if (fl_if.free_count !== 6'(exp_q.size())) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", c, fl_if.free_count, exp_q.size()); end
            checks++; if (fl_if.error !== exp_err) begin failures++; $display("FAIL rand_error[%0d] got=%0b exp=%0b", c, fl_if.error, exp_err); end
            tick();
        end
        drive(0, 0, '0, 0, 0);
    endtask

    initial begin
        n_rst = 1'b0;
        fl_if.alloc_ack    = 1'b0;
        fl_if.free_valid   = 1'b0;
        fl_if.free_tag     = '0;
        fl_if.commit_valid = 1'b0;
        fl_if.flush        = 1'b0;
        @(negedge clk);
        test_reset();
        test_drain();
        test_underflow();
        test_refill();
        test_rollback();
        test_flush_commit();
        test_overflow();
        test_bypass();
        test_random();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/d_free_list.md
# d_free_list

Free list for D-register renaming in the out-of-order core. It holds the physical D-register tags not currently mapped to any architectural register and hands one tag per cycle to the rename stage. The rename stage writes that tag into the translation table (`d_set`/`d_p_reg`). Tags freed at retirement are pushed back, and a flush reclaims every tag allocated since the last retirement.

## Interface
Parameters:
- NUM_P_REG, `` `NUM_D_REG `` (32): physical D registers. Must be a power of two.
- NUM_ARCH, 16: architectural D registers.
- P_BITS, $clog2(NUM_P_REG): tag width.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset: synchronous, active-low.
- alloc_valid  out  1  a free tag is presented on alloc_tag.
- alloc_tag  out  P_BITS  tag at the allocation head.
- alloc_ack  in  1  rename consumes alloc_tag this cycle.
- free_valid  in  1  retirement returns a tag.
- free_tag  in  P_BITS  tag being returned.
- commit_valid  in  1  the oldest allocation has retired (non-speculative).
- flush  in  1  discard all speculative allocations.
- free_count  out  P_BITS+1  tags currently allocatable.
- error  out  1  sticky; set on overflow, underflow or invalid commit.

## Operation
- Storage: circular array `mem[NUM_P_REG]` of P_BITS entries.
- Pointers, each P_BITS+1 bits wide (MSB is the wrap bit):
  - head: next tag to allocate.
  - tail: next slot to write.
  - chead: the commit head.
- free_count = tail − head. Empty when head == tail. Full when the pointers differ only in the MSB.
- Invariant: chead lies between tail and head, inclusive.
- Reset:
  - mem[i] = NUM_ARCH+i for i < NUM_P_REG−NUM_ARCH; remaining entries are 0.
  - head = chead = 0; tail = NUM_P_REG−NUM_ARCH; error = 0.
  - Tags 0..NUM_ARCH−1 are the initial architectural mappings.
- Alloc:
  - alloc_valid = (free_count != 0); alloc_tag = mem[head[P_BITS−1:0]].
  - alloc_ack with alloc_valid advances head by 1.
  - alloc_ack with alloc_valid=0 is ignored and sets error.
- Free:
  - free_valid writes mem[tail] = free_tag and advances tail.
  - free_valid when full is ignored and sets error.
- Commit:
  - commit_valid advances chead.
  - commit_valid with chead == head (nothing outstanding) is ignored and sets error.
- Flush:
  - Next head = chead after this cycle's commit is applied, i.e. chead+1 if a valid commit occurs in the same cycle.
  - alloc_ack in a flush cycle is ignored and does not set error.
  - free_valid in a flush cycle is still processed.
- Simultaneous alloc and free while not empty: both take effect; free_count is unchanged.
- Underflow/overflow checks use the current-cycle free_count, before this cycle's updates.
- error clears only on reset.

## Timing
- alloc_valid, alloc_tag and free_count are combinational from registered state. There is no clock-to-alloc latency.
- A freed tag is allocatable on the cycle after free_valid (see Configuration for the bypass).
- Pointer and error updates occur at posedge clk.
- Flush takes effect at the next edge. The following cycle presents mem[chead] as alloc_tag.
- Reset asserted mid-operation discards all state and restores the reset contents at the next edge.

## Configuration
- FREE_LIST_BYPASS_EN:
  - Defined: when empty and free_valid, alloc_valid=1 and alloc_tag=free_tag in the same cycle.
    - alloc_ack that cycle writes mem[tail], advances both tail and head, and sets no error.
    - The tag remains stored, so a later flush can reclaim it.
  - Undefined: no bypass. An empty list gives alloc_valid=0 regardless of free_valid.

## Test plan
- Reset, then 16 cycles of alloc_ack:
  - alloc_tag sequence is 16,17,…,31.
  - free_count counts 16→0; then alloc_valid=0, error=0.
- From empty, free_valid with tag 5, then with tag 9:
  - Next cycles: alloc_tag=5 then 9; free_count=2; error stays 0.
- Speculative rollback:
  - Allocate 16,17,18; commit_valid once; then flush.
  - Next cycle: alloc_tag=17, free_count=15.
- Flush with commit in the same cycle:
  - After allocating 16,17 with nothing committed, assert flush+commit_valid.
  - head equals chead=1; alloc_tag=17.
- Error cases:
  - alloc_ack when empty → error=1 and head unchanged.
  - After re-reset, free_valid ×17 into a full list of 32 → 17th ignored, error=1.
- With FREE_LIST_BYPASS_EN, empty list, free_valid with tag 7 plus alloc_ack:
  - Same cycle: alloc_valid=1, alloc_tag=7.
  - Next cycle: free_count=0, error=0.
